sa_hsync_tx: RTL and testbench
==============================

# sa_hsync_tx

Source-side end of a two-phase (toggle) request/acknowledge crossing. It accepts data beats from a local valid/ready producer and presents each one to a far clock domain as a stable data bus plus a request toggle. It synchronizes the far domain's acknowledge toggle back through a 3-flop synchronizer and retires the beat. It sits in the sending domain, opposite the receiving-side 3-stage synchronizer/capture logic, and holds one skid entry so the producer is not stalled for a full round trip.

## Interface
- WIDTH, 32, payload width in bits
- CNT_W, 16, width of the retired-beat counter
- clk  in  1  sending-domain clock; all state on posedge
- reset_  in  1  asynchronous, active-low reset; asserted asynchronously, released synchronously to clk by the integrator
- src_pvld  in  1  producer beat valid
- src_prdy  out  1  block can accept a beat this cycle
- src_pd  in  WIDTH  producer payload
- req_tgl  out  1  request toggle to far domain; each transition announces one beat
- req_pd  out  WIDTH  payload to far domain; stable while a beat is outstanding
- ack_tgl  in  1  acknowledge toggle from far domain, asynchronous to clk
- busy  out  1  a beat is outstanding (request not yet acknowledged)
- tx_cnt  out  CNT_W  count of acknowledged beats, wraps modulo 2^CNT_W

## Operation
- Reset values: req_tgl=0, req_pd=0, ack synchronizer flops=0, state IDLE, skid buffer empty (buf_vld=0, buf_pd=0), busy=0, tx_cnt=0; src_prdy=1 throughout reset.
- Acceptance: pvld & prdy. src_prdy = !buf_vld (combinational from a register only, never from src_pvld).
- ack_s = third flop of the ack synchronizer. done = (state==BUSY) & (ack_s==req_tgl).
- IDLE: ack_s is ignored. On acceptance, req_pd<=src_pd, req_tgl<=~req_tgl, go BUSY.
- BUSY, !done: an acceptance loads the skid buffer (buf_pd<=src_pd, buf_vld<=1). req_pd and req_tgl hold.
- BUSY, done: tx_cnt increments. The next beat is launched in the same edge with priority buf > new acceptance:
  - If buf_vld: req_pd<=buf_pd, toggle, stay BUSY. Any new acceptance in this cycle refills the buffer. It can only occur if buf_vld was 0, so this case has no acceptance.
  - Else if acceptance: bypass src_pd directly into req_pd, toggle, stay BUSY.
  - Else: go IDLE.
- busy = (state==BUSY).
- tx_cnt wraps from all-ones to 0 without any flag.
- Reset mid-operation discards the outstanding beat and the buffered beat, and req_tgl returns to 0. The far side must be reset in the same reset domain. No recovery handshake.

## Timing
- Toggle launch: req_tgl and req_pd change on the edge after acceptance in IDLE. Both change on the same edge.
- req_pd changes only on the edge that flips req_tgl. It is stable for at least the full round trip.
- Ack latency: a change on ack_tgl reaches ack_s after 3 clk edges.
- With an external loopback (ack_tgl=req_tgl), the round-trip period is 4 cycles per beat:
  - toggle at edge E0
  - done true in the cycle after E3
  - next toggle at E4
- Max two beats in the block at once: one outstanding and one buffered.

## Structure
- Package sa_hsync_pkg holds:
  - state enum {IDLE, BUSY}
  - localparam SYNC_DEPTH=3
- Sub-module sa_sync3_bit: a SYNC_DEPTH-flop single-bit synchronizer that resets to 0 on reset_. It is instantiated once for ack_tgl.
- All remaining logic (FSM, skid buffer, counter) sits in the top-level module.

## Test plan
- Reset: hold reset_=0 with random inputs. Required: req_tgl=0, req_pd=0, busy=0, tx_cnt=0, src_prdy=1. Assert reset_ asynchronously mid-cycle and confirm the outputs clear without a clk edge.
- Single beat, loopback: src_pd=0xA5A5_0001, one cycle of pvld.
  - Next edge: req_tgl=1, req_pd=0xA5A5_0001, busy=1.
  - Four edges after the toggle: busy=0, tx_cnt=1.
- Back-to-back, loopback: pvld held with payloads 1, 2, 3.
  - src_prdy drops after the second accept.
  - req_tgl flips every 4 cycles with req_pd=1, 2, 3 in order.
  - tx_cnt=3 and busy=0 at the end.
- Bypass on done: buffer empty, new beat 0x55 presented exactly in the done cycle. Required: the next edge toggles with req_pd=0x55, and busy stays 1.
- Stalled far side: ack_tgl held at 0 after one toggle.
  - A second beat is accepted into the buffer; a third sees src_prdy=0.
  - req_pd stays constant for 100 cycles.
  - Releasing the ack launches the buffered beat 4 cycles later.
- Counter wrap and mid-flight reset:
  - With CNT_W=4, 16 beats give tx_cnt=0.
  - Asserting reset_ while busy=1 with buf_vld=1 gives every output at its reset value, and the next beat starts from req_tgl=0.

Source files
------------

// File: rtl/sa_hsync_pkg.sv
// Shared types and constants for the two-phase handshake source block.
package sa_hsync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int SYNC_DEPTH = 3;

endpackage

// File: rtl/sa_hsync_tx_if.sv
// Producer handshake plus far-domain request/acknowledge bundle.
// master is the sending block; slave is whatever drives the producer side and returns the ack.
interface sa_hsync_tx_if #(
  parameter int WIDTH = 32
);

  logic             src_pvld;
  logic             src_prdy;
  logic [WIDTH-1:0] src_pd;
  logic             req_tgl;
  logic [WIDTH-1:0] req_pd;
  logic             ack_tgl;

  modport master (
    input  src_pvld,
    input  src_pd,
    input  ack_tgl,
    output src_prdy,
    output req_tgl,
    output req_pd
  );

  modport slave (
    output src_pvld,
    output src_pd,
    output ack_tgl,
    input  src_prdy,
    input  req_tgl,
    input  req_pd
  );

endinterface

// File: rtl/sa_sync3_bit.sv
// Single-bit multi-flop synchronizer for a signal arriving from another clock domain.
module sa_sync3_bit
  import sa_hsync_pkg::*;
(
  input  logic clk,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_r;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync_r <= {SYNC_DEPTH{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = sync_r[SYNC_DEPTH-1];

endmodule

// File: rtl/sa_hsync_tx.sv
// Source side of a toggle request/acknowledge crossing with a one-entry skid buffer,
// so the producer can hand over the next beat while the current one is in flight.
module sa_hsync_tx
  import sa_hsync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_,
  sa_hsync_tx_if.master    bus,
  output logic             busy,
  output logic [CNT_W-1:0] tx_cnt
);

  state_e           state_r;
  logic             req_tgl_r;
  logic [WIDTH-1:0] req_pd_r;
  logic             buf_vld_r;
  logic [WIDTH-1:0] buf_pd_r;
  logic [CNT_W-1:0] tx_cnt_r;

  logic ack_s;
  logic accept_s;
  logic done_s;

  sa_sync3_bit u_ack_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d      (bus.ack_tgl),
    .q      (ack_s)
  );

  // Ready follows skid occupancy only, never the producer's valid.
  assign bus.src_prdy = ~buf_vld_r;
  assign accept_s     = bus.src_pvld & ~buf_vld_r;
  assign done_s       = (state_r == BUSY) & (ack_s == req_tgl_r);

  assign bus.req_tgl  = req_tgl_r;
  assign bus.req_pd   = req_pd_r;
  assign busy         = (state_r == BUSY);
  assign tx_cnt       = tx_cnt_r;

  // Launch/retire FSM together with the skid buffer and retired-beat counter.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r   <= IDLE;
      req_tgl_r <= 1'b0;
      req_pd_r  <= {WIDTH{1'b0}};
      buf_vld_r <= 1'b0;
      buf_pd_r  <= {WIDTH{1'b0}};
      tx_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_pd_r  <= bus.src_pd;
            req_tgl_r <= ~req_tgl_r;
            state_r   <= BUSY;
          end
        end
        BUSY: begin
          if (done_s) begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
            // A buffered beat is older than anything on src_pd, so it goes first.
            if (buf_vld_r) begin
              req_pd_r  <= buf_pd_r;
              req_tgl_r <= ~req_tgl_r;
              buf_vld_r <= 1'b0;
            end else if (accept_s) begin
              req_pd_r  <= bus.src_pd;
              req_tgl_r <= ~req_tgl_r;
            end else begin
              state_r <= IDLE;
            end
          end else if (accept_s) begin
            buf_pd_r  <= bus.src_pd;
            buf_vld_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_hsync_tx.sv
// Scoreboard bench for sa_hsync_tx: beats accepted from the producer are queued, and a
// beat-level model predicts launches, retirements, ready and the retired count.
module tb_sa_hsync_tx;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset_;
  logic             loop_en;
  logic             ack_hold;
  logic             busy;
  logic [CNT_W-1:0] tx_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [WIDTH-1:0] pd;
    int               edge_n;
  } beat_t;

  beat_t exp_q[$];

  sa_hsync_tx_if #(.WIDTH(WIDTH)) bus ();

  // Loopback returns the request toggle as the ack; otherwise the bench holds the ack.
  assign bus.ack_tgl = loop_en ? bus.req_tgl : ack_hold;

  sa_hsync_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus),
    .busy   (busy),
    .tx_cnt (tx_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer side of the scoreboard: every completed handshake becomes an expected beat.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset_ === 1'b1 && bus.src_pvld === 1'b1 && bus.src_prdy === 1'b1) begin
        exp_q.push_back('{pd: bus.src_pd, edge_n: cyc + 1});
      end
    end
  end

  // Beat-level model: one beat in flight, retired four edges after the ack is seen.
  bit               m_outst   = 1'b0;
  bit               m_ackseen = 1'b0;
  int               m_ackcyc  = 0;
  int               m_ret     = 0;
  logic             m_par     = 1'b0;
  logic [WIDTH-1:0] m_cur     = '0;
  logic             m_prev    = 1'b0;

  initial begin
    beat_t b;
    bit    launch_exp;
    int    nbuf;
    forever begin
      @(negedge clk);
      if (reset_ !== 1'b1) begin
        exp_q.delete();
        m_outst = 1'b0; m_ackseen = 1'b0; m_ret = 0;
        m_par = 1'b0; m_cur = '0; m_prev = 1'b0;
        chk("rst_req_tgl", bus.req_tgl, 64'd0);
        chk("rst_req_pd", bus.req_pd, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_tx_cnt", tx_cnt, 64'd0);
        chk("rst_src_prdy", bus.src_prdy, 64'd1);
      end else begin
        if (m_outst && m_ackseen && cyc == m_ackcyc + 4) begin
          m_outst = 1'b0;
          m_ackseen = 1'b0;
          m_ret = m_ret + 1;
        end
        launch_exp = !m_outst && exp_q.size() > 0 && exp_q[0].edge_n <= cyc;
        chk("launch", bus.req_tgl != m_prev, launch_exp);
        if (launch_exp) begin
          b = exp_q.pop_front();
          m_cur = b.pd;
          m_par = ~m_par;
          m_outst = 1'b1;
        end
        m_prev = bus.req_tgl;
        if (m_outst && !m_ackseen && bus.ack_tgl == m_par) begin
          m_ackseen = 1'b1;
          m_ackcyc = cyc;
        end
        nbuf = 0;
        foreach (exp_q[i]) if (exp_q[i].edge_n <= cyc) nbuf = nbuf + 1;
        chk("req_tgl", bus.req_tgl, m_par);
        chk("req_pd", bus.req_pd, m_cur);
        chk("busy", busy, m_outst);
        chk("tx_cnt", tx_cnt, m_ret % CNT_MOD);
        chk("src_prdy", bus.src_prdy, (int'(m_outst) + nbuf) < 2);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] pd);
    int n = 0;
    bit acc;
    bus.src_pvld = 1'b1;
    bus.src_pd   = pd;
    do begin
      acc = bus.src_prdy;
      tick();
      n = n + 1;
    end while (!acc && n < 200);
    chk("send_accept", acc, 64'd1);
    bus.src_pvld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !bus.src_prdy) && n < 100) begin
      tick();
      n = n + 1;
    end
    chk("idle_reached", busy, 64'd0);
  endtask

  initial begin
    logic [CNT_W-1:0] base;
    reset_ = 1'b0; loop_en = 1'b0; ack_hold = 1'b0;
    bus.src_pvld = 1'b0; bus.src_pd = '0;

    // Random inputs while held in reset.
    repeat (6) begin
      tick();
      bus.src_pvld = 1'($urandom_range(0, 1));
      bus.src_pd   = $urandom;
      ack_hold     = 1'($urandom_range(0, 1));
    end
    bus.src_pvld = 1'b0; ack_hold = 1'b0; loop_en = 1'b1;
    tick();
    reset_ = 1'b1;
    tick();

    // Single beat in loopback.
    bus.src_pd = 32'hA5A5_0001; bus.src_pvld = 1'b1;
    tick();
    bus.src_pvld = 1'b0;
    chk("single_tgl", bus.req_tgl, 64'd1);
    chk("single_pd", bus.req_pd, 64'hA5A5_0001);
    chk("single_busy", busy, 64'd1);
    repeat (3) tick();
    chk("single_busy_e3", busy, 64'd1);
    tick();
    chk("single_done_busy", busy, 64'd0);
    chk("single_cnt", tx_cnt, 64'd1);

    // Back-to-back beats with valid held.
    base = tx_cnt;
    send(32'd1);
    send(32'd2);
    chk("b2b_prdy_drop", bus.src_prdy, 64'd0);
    send(32'd3);
    wait_idle();
    chk("b2b_cnt", tx_cnt, 64'(CNT_W'(base + CNT_W'(3))));

    // New beat offered exactly in the done cycle with the buffer empty.
    send(32'h11);
    repeat (3) tick();
    bus.src_pd = 32'h55; bus.src_pvld = 1'b1;
    tick();
    bus.src_pvld = 1'b0;
    chk("bypass_pd", bus.req_pd, 64'h55);
    chk("bypass_busy", busy, 64'd1);
    wait_idle();

    // Far side stalled: one outstanding, one buffered, a third refused.
    ack_hold = bus.req_tgl; loop_en = 1'b0;
    send(32'h100);
    send(32'h200);
    chk("stall_prdy", bus.src_prdy, 64'd0);
    bus.src_pd = 32'h300; bus.src_pvld = 1'b1;
    repeat (100) begin
      tick();
      chk("stall_pd_hold", bus.req_pd, 64'h100);
    end
    chk("stall_third_blocked", bus.src_prdy, 64'd0);
    ack_hold = ~ack_hold;
    repeat (3) tick();
    chk("release_pd_e3", bus.req_pd, 64'h100);
    tick();
    chk("release_pd_e4", bus.req_pd, 64'h200);
    begin
      int n = 0;
      while (!bus.src_prdy && n < 20) begin tick(); n = n + 1; end
      chk("release_third_prdy", bus.src_prdy, 64'd1);
    end
    tick();
    bus.src_pvld = 1'b0;
    loop_en = 1'b1;
    wait_idle();

    // Randomized traffic in loopback.
    repeat (300) begin
      bus.src_pvld = ($urandom_range(0, 3) != 0);
      bus.src_pd   = $urandom;
      tick();
    end
    bus.src_pvld = 1'b0;
    wait_idle();

    // Reset asserted mid-cycle with a beat outstanding and another buffered.
    ack_hold = bus.req_tgl; loop_en = 1'b0;
    send(32'hAAA);
    send(32'hBBB);
    chk("mid_busy", busy, 64'd1);
    chk("mid_buf_full", bus.src_prdy, 64'd0);
    @(posedge clk);
    #3;
    reset_ = 1'b0;
    #1;
    chk("async_req_tgl", bus.req_tgl, 64'd0);
    chk("async_req_pd", bus.req_pd, 64'd0);
    chk("async_busy", busy, 64'd0);
    chk("async_tx_cnt", tx_cnt, 64'd0);
    chk("async_prdy", bus.src_prdy, 64'd1);
    ack_hold = 1'b0; loop_en = 1'b1;
    repeat (2) tick();
    reset_ = 1'b1;
    tick();

    // Sixteen beats after reset wrap the 4-bit counter to zero.
    send(32'h1);
    chk("post_rst_tgl", bus.req_tgl, 64'd1);
    for (int i = 2; i <= 16; i++) send(32'(i));
    wait_idle();
    chk("wrap_cnt", tx_cnt, 64'd0);
    chk("scoreboard_empty", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors = errors + 1;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
